// File: rtl/srambank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : srambank_arbiter
// Purpose  : Two-requester arbiter/sequencer in front of one synchronous SRAM
//            bank (1-cycle registered read). Issues at most one bank operation
//            per cycle and steers read data back to the issuing requester
//            through a per-requester one-entry response slot.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_valid/ready     - per-requester request handshake (2 bits)
//            req_write           - 1 = write, 0 = read, per requester
//            req_addr/req_wdata  - packed per-requester address / write data
//            rsp_valid/ready     - per-requester read-response handshake
//            rsp_rdata           - packed per-requester read data
//            bank_addr/wd        - bank address / write data (0 when idle)
//            bank_sel/read/write - bank strobes
//            bank_dataout        - registered bank read data
// Options  : SRAMARB_FIXED_PRI_EN - when defined, requester 0 always wins and
//            the round-robin pointer is removed; otherwise round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module srambank_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_write,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [2*DW-1:0] rsp_rdata,
    output logic [AW-1:0]   bank_addr,
    output logic [DW-1:0]   bank_wd,
    output logic            bank_sel,
    output logic            bank_read,
    output logic            bank_write,
    input  logic [DW-1:0]   bank_dataout
);

    // In-flight read tracking: valid during the cycle after a read grant,
    // which is exactly the cycle bank_dataout holds that read's data.
    logic            r_pend_valid;
    logic            r_pend_id;
    logic [1:0]      r_rsp_valid;
    logic [2*DW-1:0] r_rsp_rdata;

    logic [1:0]      w_eligible;
    logic            w_grant;
    logic            w_win;

    // A read is only eligible when its requester has nothing outstanding:
    // neither in the bank pipeline nor parked in its response slot. Writes
    // never produce a response, so they are always eligible.
    generate
        for (genvar i = 0; i < 2; i++) begin : g_elig
            assign w_eligible[i] = req_valid[i] &
                                   (req_write[i] |
                                    (~(r_pend_valid & (r_pend_id == 1'(i))) &
                                     ~r_rsp_valid[i]));
        end
    endgenerate

`ifdef SRAMARB_FIXED_PRI_EN
    // Requester 1 wins only when requester 0 is not eligible.
    always_comb begin
        w_win = ~w_eligible[0];
    end
`else
    logic r_last;

    // Contention goes to the requester that did not win last; otherwise the
    // single eligible requester wins. A blocked requester is simply not
    // eligible, so it never burns its turn.
    always_comb begin
        w_win = w_eligible[1];
        if (w_eligible == 2'b11) begin
            w_win = ~r_last;
        end
    end
`endif

    assign w_grant = ~reset & (|w_eligible);

    always_comb begin
        req_ready  = 2'b00;
        bank_sel   = 1'b0;
        bank_read  = 1'b0;
        bank_write = 1'b0;
        bank_addr  = '0;
        bank_wd    = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
            bank_sel         = 1'b1;
            bank_write       = req_write[w_win];
            bank_read        = ~req_write[w_win];
            bank_addr        = w_win ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
            bank_wd          = w_win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_id    <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
`ifndef SRAMARB_FIXED_PRI_EN
            r_last       <= 1'b1;
`endif
        end else begin
            r_pend_valid <= w_grant & ~req_write[w_win];
            if (w_grant) begin
                r_pend_id <= w_win;
`ifndef SRAMARB_FIXED_PRI_EN
                r_last    <= w_win;
`endif
            end

            // Pop clears only the valid flag; data stays for observability.
            for (int i = 0; i < 2; i++) begin
                if (rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end

            // The owner's slot is guaranteed empty here (eligibility), so a
            // capture can never collide with a pop of the same slot.
            if (r_pend_valid) begin
                r_rsp_valid[r_pend_id] <= 1'b1;
                if (r_pend_id) begin
                    r_rsp_rdata[2*DW-1:DW] <= bank_dataout;
                end else begin
                    r_rsp_rdata[DW-1:0]    <= bank_dataout;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_srambank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_srambank_arbiter
// Purpose  : Self-checking bench for srambank_arbiter. Contains a 1024x16
//            bank model, a transaction-level reference model compared every
//            cycle, and directed sequences with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srambank_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = 2'b00;
    logic [19:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_rdata;
    logic [9:0]  bank_addr;
    logic [15:0] bank_wd;
    logic        bank_sel;
    logic        bank_read;
    logic        bank_write;
    logic [15:0] bank_dataout = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    srambank_arbiter #(.AW(10), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .bank_addr    (bank_addr),
        .bank_wd      (bank_wd),
        .bank_sel     (bank_sel),
        .bank_read    (bank_read),
        .bank_write   (bank_write),
        .bank_dataout (bank_dataout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank: write-priority, registered read, dataout changes only on a read.
    logic [15:0] bank_mem [0:1023];
    always @(posedge clk) begin
        if (bank_sel) begin
            if (bank_write) bank_mem[bank_addr] <= bank_wd;
            else if (bank_read) bank_dataout <= bank_mem[bank_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per requester, at most one outstanding read that
    // becomes visible as a response two cycles after its grant, carrying
    // the memory contents at grant time.
    // ------------------------------------------------------------------
    logic [15:0] m_mem [0:1023];
    int          m_last = 1;
    bit          m_rv [2];
    logic [15:0] m_rd [2];
    bit          m_fv [2];
    int          m_fdue [2];
    logic [15:0] m_fd [2];

    initial begin : p_model
        int          win;
        logic [1:0]  el;
        logic [1:0]  e_ready;
        logic        e_sel, e_wr, e_rd;
        logic [9:0]  e_addr;
        logic [15:0] e_wd;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 0; m_rd[i] = '0; m_fv[i] = 0; m_fdue[i] = 0; m_fd[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_fv[i] && m_fdue[i] == cyc) begin
                    m_rv[i] = 1; m_rd[i] = m_fd[i]; m_fv[i] = 0;
                end
            end
            for (int i = 0; i < 2; i++)
                el[i] = req_valid[i] && (req_write[i] || (!m_fv[i] && !m_rv[i]));
            win = -1;
            if (!reset) begin
`ifdef SRAMARB_FIXED_PRI_EN
                if (el[0]) win = 0;
                else if (el[1]) win = 1;
`else
                if (el == 2'b11) win = (m_last == 0) ? 1 : 0;
                else if (el[0]) win = 0;
                else if (el[1]) win = 1;
`endif
            end
            e_ready = 2'b00; e_sel = 0; e_wr = 0; e_rd = 0; e_addr = '0; e_wd = '0;
            if (win >= 0) begin
                e_ready[win] = 1'b1;
                e_sel  = 1'b1;
                e_wr   = req_write[win];
                e_rd   = !req_write[win];
                e_addr = req_addr[win*10 +: 10];
                e_wd   = req_wdata[win*16 +: 16];
            end
            chk("req_ready",  {30'd0, req_ready}, {30'd0, e_ready});
            chk("bank_strobes", {29'd0, bank_sel, bank_read, bank_write}, {29'd0, e_sel, e_rd, e_wr});
            chk("bank_addr",  {22'd0, bank_addr}, {22'd0, e_addr});
            chk("bank_wd",    {16'd0, bank_wd}, {16'd0, e_wd});
            chk("rsp_valid",  {30'd0, rsp_valid}, {30'd0, m_rv[1], m_rv[0]});
            chk("rsp_rdata",  rsp_rdata, {m_rd[1], m_rd[0]});
            // Effects of the upcoming edge (inputs are stable until then).
            if (reset) begin
                m_last = 1;
                for (int i = 0; i < 2; i++) begin
                    m_rv[i] = 0; m_rd[i] = '0; m_fv[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++)
                    if (rsp_ready[i]) m_rv[i] = 0;
                if (win >= 0) begin
                    m_last = win;
                    if (req_write[win]) m_mem[e_addr] = e_wd;
                    else begin
                        m_fv[win] = 1; m_fdue[win] = cyc + 2; m_fd[win] = m_mem[e_addr];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left just after a rising edge)
    // ------------------------------------------------------------------
    task automatic issue(input int r, input bit wr, input logic [9:0] a,
                         input logic [15:0] d, output int gcyc);
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*10 +: 10]  = a;
        req_wdata[r*16 +: 16] = d;
        gcyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) chk("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int r, output int vcyc);
        vcyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[r]) begin
                vcyc = cyc;
                break;
            end
        end
        if (vcyc < 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop(input int r);
        @(posedge clk); #1;
        rsp_ready[r] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[r] = 1'b0;
    endtask

    initial begin : p_timeout
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequences
    // ------------------------------------------------------------------
    initial begin : p_main
        int g, c;
        logic [1:0] grants [4];

        // Reset held with both requesters asking for writes.
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {10'h200, 10'h100};
        req_wdata = {16'h2222, 16'h1111};
        repeat (2) begin
            @(negedge clk);
            chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
            chk("reset_bank_sel",  {31'd0, bank_sel}, 32'd0);
            chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Round-robin (or fixed priority) under continuous write pressure.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            grants[k] = req_ready;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("first_grant_req0", {30'd0, grants[0]}, 32'd1);
`ifdef SRAMARB_FIXED_PRI_EN
        chk("fixed_grant1", {30'd0, grants[1]}, 32'd1);
        chk("fixed_grant2", {30'd0, grants[2]}, 32'd1);
        chk("fixed_grant3", {30'd0, grants[3]}, 32'd1);
`else
        chk("rr_grant1", {30'd0, grants[1]}, 32'd2);
        chk("rr_grant2", {30'd0, grants[2]}, 32'd1);
        chk("rr_grant3", {30'd0, grants[3]}, 32'd2);
`endif

        // Preload through the arbiter.
        issue(0, 1'b1, 10'h010, 16'h1234, g);
        issue(1, 1'b1, 10'h001, 16'hAAAA, g);
        issue(1, 1'b1, 10'h020, 16'h0F0F, g);

        // Write then read back.
        issue(0, 1'b1, 10'h3A5, 16'hBEEF, g);
        issue(0, 1'b0, 10'h3A5, 16'h0000, g);
        wait_rsp(0, c);
        chk("readback_latency", c - g, 32'd2);
        chk("readback_data", {16'd0, rsp_rdata[15:0]}, 32'h0000BEEF);
        pop(0);

        // Backpressure on requester 1's response slot.
        issue(1, 1'b0, 10'h010, 16'h0000, g);
        wait_rsp(1, c);
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[19:10] = 10'h020;
        repeat (5) begin
            @(negedge clk);
            chk("bp_blocked", {31'd0, req_ready[1]}, 32'd0);
            chk("bp_hold_data", {16'd0, rsp_rdata[31:16]}, 32'h00001234);
        end
        @(posedge clk); #1;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        chk("bp_granted_after_pop", {31'd0, req_ready[1]}, 32'd1);
        chk("bp_popped", {31'd0, rsp_valid[1]}, 32'd0);
        chk("bp_data_kept", {16'd0, rsp_rdata[31:16]}, 32'h00001234);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(1, c);
        chk("bp_second_data", {16'd0, rsp_rdata[31:16]}, 32'h00000F0F);
        pop(1);

        // Read by 0, then write by 1 to the same address the next cycle.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[9:0] = 10'h001;
        @(negedge clk);
        chk("il_read_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        req_write[1] = 1'b1;
        req_addr[19:10] = 10'h001;
        req_wdata[31:16] = 16'h5555;
        @(negedge clk);
        chk("il_write_grant", {30'd0, req_ready}, 32'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(0, c);
        chk("il_old_data", {16'd0, rsp_rdata[15:0]}, 32'h0000AAAA);
        pop(0);
        issue(0, 1'b0, 10'h001, 16'h0000, g);
        wait_rsp(0, c);
        chk("il_new_data", {16'd0, rsp_rdata[15:0]}, 32'h00005555);
        pop(0);

        // Reset in the cycle after a read grant discards the read.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[9:0] = 10'h3A5;
        @(negedge clk);
        chk("mr_read_grant", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("mr_no_response", {30'd0, rsp_valid}, 32'd0);
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
